// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage.
// Contents: XLEN, load/store funct3 encodings, LSU FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Load/store access size and sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/grant/valid bus between the LSU and the data memory.
// master: LSU side (drives request fields, receives gnt/rvalid/rdata)
// slave : memory side
interface lsu_mem_stage_if;
  import riscv_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the LSU.
// Inputs : live M-stage op/funct3/address low bits/store data; latched
//          funct3/lane and the returned memory word for load extraction.
// Outputs: legal/fault decode, byte enables, lane-replicated store data,
//          extracted and extended load data.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] st_data,
  output logic            legal,
  output logic            fault,
  output logic [3:0]      be,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_lane,
  input  logic [XLEN-1:0] ld_word,
  output logic [XLEN-1:0] ld_data
);

  logic            bad_f3;
  logic            misalign;
  logic [XLEN-1:0] ld_shift;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Access legality: exactly one op, funct3 valid for that op, aligned
  always_comb begin
    bad_f3 = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = mem_write;
      default:          bad_f3 = 1'b1;
    endcase
    misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3 == F3_W) && (addr_lo != 2'b00));
    legal    = (mem_read ^ mem_write) && !bad_f3 && !misalign;
    // Any memory op that is not legal (including read+write together) faults
    fault    = (mem_read | mem_write) && !legal;
  end

  // Store byte enables and lane replication (funct3[1:0] gives the size)
  always_comb begin
    be       = 4'b1111;
    st_wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'(4'b0001 << addr_lo);
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    ld_shift = ld_word >> {ld_lane, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one data-memory access per M-stage
// load/store, stalls the pipeline until it completes, and registers the
// extended load result for the M/W register.
// Ports: clk, reset_n (sync active-low); MemReadM/MemWriteM/funct3M/
//        ALUResultM/WriteDataM from M stage; ReadDataM (registered),
//        StallM, FaultM; mem_if master port to the data memory.
module lsu_mem_stage
  import riscv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [2:0]             funct3M,
  input  logic [XLEN-1:0]        ALUResultM,
  input  logic [XLEN-1:0]        WriteDataM,
  output logic [XLEN-1:0]        ReadDataM,
  output logic                   StallM,
  output logic                   FaultM,
  lsu_mem_stage_if.master        mem_if
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            req_c, stall_c, fault_c;
  logic            al_legal, al_fault;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_ld_data, word_addr;

  assign word_addr = {ALUResultM[XLEN-1:2], 2'b00};

  lsu_lane_align u_align (
    .mem_read  (MemReadM),
    .mem_write (MemWriteM),
    .funct3    (funct3M),
    .addr_lo   (ALUResultM[1:0]),
    .st_data   (WriteDataM),
    .legal     (al_legal),
    .fault     (al_fault),
    .be        (al_be),
    .st_wdata  (al_wdata),
    .ld_funct3 (f3_q),
    .ld_lane   (lane_q),
    .ld_word   (mem_if.mem_rdata),
    .ld_data   (al_ld_data)
  );

  // State and latched access fields
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state, latch updates and bus/pipeline outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    fault_c = 1'b0;
    mem_if.mem_we    = we_q;
    mem_if.mem_addr  = addr_q;
    mem_if.mem_be    = be_q;
    mem_if.mem_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        // Issue cycle presents the live fields; later cycles use the latch
        mem_if.mem_we    = MemWriteM;
        mem_if.mem_addr  = word_addr;
        mem_if.mem_be    = al_be;
        mem_if.mem_wdata = al_wdata;
        if (al_legal) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          addr_d  = word_addr;
          be_d    = al_be;
          wdata_d = al_wdata;
          we_d    = MemWriteM;
          f3_d    = funct3M;
          lane_d  = ALUResultM[1:0];
          if (mem_if.mem_gnt) state_d = MemWriteM ? DONE : WAIT;
          else                state_d = REQ;
        end else if (al_fault) begin
          fault_c = 1'b1;
          rdata_d = '0;
        end
      end
      REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_if.mem_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_c = 1'b1;
        if (mem_if.mem_rvalid) begin
          rdata_d = al_ld_data;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are suppressed combinationally while reset is held
  assign mem_if.mem_req = req_c & reset_n;
  assign StallM         = stall_c & reset_n;
  assign FaultM         = fault_c & reset_n;
  assign ReadDataM      = rdata_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the Memory stage of the pipelined RISC-V core. It is the producer side of the M/W data handoff. It takes the M-stage address, store data and control, and runs a request/grant/valid handshake with a variable-latency data memory. It delivers the sign/zero-extended `ReadDataM` that the M/W pipeline register captures, and holds `StallM` while a memory access is outstanding.

## Interface
- Parameters: none; widths are fixed at XLEN = 32.
- Ports (reset is synchronous, active-low; single clock):
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  synchronous active-low reset
- `MemReadM`  in  1  load in M stage
- `MemWriteM`  in  1  store in M stage
- `funct3M`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- `ALUResultM`  in  32  byte address
- `WriteDataM`  in  32  store data, right-justified
- `ReadDataM`  out  32  extended load result, registered
- `StallM`  out  1  freezes F/D/E/M registers; M/W captures only when low
- `FaultM`  out  1  one-cycle pulse: misaligned or illegal access
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word address, `ALUResultM & ~3`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-aligned store data
- `mem_gnt`  in  1  request accepted this cycle when `mem_req` is high
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word

## Operation
- FSM states and transitions:
  - IDLE:
    - An access is legal if exactly one of `MemReadM`/`MemWriteM` is set, `funct3M` is legal for that op, and the address is aligned.
    - A legal access drives `mem_req` combinationally and asserts `StallM` in the same cycle. The address, byte enables, write data, `funct3` and the low address bits are latched.
    - With `mem_gnt`: a store goes to DONE; a load goes to WAIT.
    - Without `mem_gnt`: go to REQ.
  - REQ: hold `mem_req` with the latched, stable fields until `mem_gnt`. Then a store goes to DONE and a load goes to WAIT. `StallM` = 1.
  - WAIT: `StallM` = 1. On `mem_rvalid`, extract the lane, extend it into `ReadDataM`, and go to DONE.
  - DONE: `StallM` = 0 so the instruction advances into W; no new request is issued this cycle; next state is IDLE.
- Lane rules:
  - Byte access: lane = `addr[1:0]`, `mem_be` = 0001 << lane, wdata byte replicated ×4.
  - Half access: lane = `addr[1]`, `mem_be` = 0011 or 1100, wdata half replicated ×2.
  - Word access: `mem_be` = 1111.
  - B/H loads sign-extend; BU/HU loads zero-extend.
- Faults:
  - Misaligned cases: H with `addr[0]` = 1; W with `addr[1:0]` ≠ 0.
  - Illegal cases: `funct3` 011, 110 or 111; a store with `funct3` 1xx; both read and write set.
  - On a fault in IDLE: no request is issued, `FaultM` = 1 for one cycle, `StallM` = 0, `ReadDataM` is loaded with 0.
- Non-memory instruction in IDLE: no request, no stall, `ReadDataM` holds.
- `mem_rvalid` in IDLE, REQ or DONE is ignored.
- `mem_gnt` and `mem_rvalid` in the same cycle in IDLE or REQ: the grant is taken and the rvalid is ignored. Memory must return read data at least one cycle after grant.

## Timing
- Reset values (`reset_n` low at a clock edge): state = IDLE, `ReadDataM` = 0.
- While `reset_n` is low, `mem_req`, `StallM` and `FaultM` are forced to 0, combinationally gated.
- Reset mid-access (REQ/WAIT) abandons the access. A late `mem_rvalid` after reset is dropped.
- Latency with zero-wait memory (gnt in the issue cycle, rvalid one cycle later):
  - Load: stall 2 cycles. IDLE (stall), WAIT (rvalid, stall), DONE (advance). `ReadDataM` is valid from the DONE cycle.
  - Store: stall 1 cycle. IDLE (gnt, stall), DONE (advance).
- Each cycle of `mem_gnt` or `mem_rvalid` delay adds exactly one stall cycle.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE. Minimum spacing is one DONE cycle.
- `ReadDataM` is stable from DONE until the next load completion or fault.

## Structure
- The shared package `riscv_pkg` holds:
  - the `funct3` load/store encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `lsu_state_t` enum (IDLE, REQ, WAIT, DONE).
- One combinational sub-module, `lsu_lane_align`, holds store lane replication, byte-enable generation, load lane extraction/extension and the fault decode. The top level holds the FSM and registers.

## Test plan
- LW at 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF → `StallM` 1,1,0; `ReadDataM` = 0xDEADBEEF in DONE; `mem_be` = 1111.
- LB at 0x103, rdata 0x80123456 → `ReadDataM` = 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012.
- SB of 0x000000A5 at 0x101, gnt delayed 3 cycles → `mem_req` held 4 cycles, `mem_be` = 0010, `mem_wdata` = 0xA5A5A5A5, addr stable at 0x100, `StallM` high 4 cycles.
- LW at 0x102 → `FaultM` pulses once, no `mem_req`, `StallM` 0, `ReadDataM` = 0.
- LW issued and granted, `reset_n` low during WAIT, then `mem_rvalid` arrives → state IDLE, `ReadDataM` = 0, rvalid ignored, `StallM` 0.
- SW followed immediately by LH at 0x2, both zero-wait → the second `mem_req` rises exactly one cycle after the store's DONE; no duplicate store issued.
